spi_ram_slave_p: RTL and testbench
==================================

Name: spi_ram_slave_p

Overview:
Parametrised SPI slave with an on-chip single-port RAM. It is the next-generation SPI/RAM wrapper. The SPI bit clock is the system clock `clk`, with one MOSI bit sampled per rising edge. It generalises data, address and depth widths and adds an optional auto-increment burst mode, frame-error detection and abort handling. It sits directly behind the chip-level SPI pins.

Parameters:
DATA_WIDTH, 8, payload width and RAM word width; frame width FW = DATA_WIDTH+2.
ADDR_WIDTH, 8, RAM address width; must be <= DATA_WIDTH; address = payload[ADDR_WIDTH-1:0].
MEM_DEPTH, 256, number of RAM words; must be <= 2**ADDR_WIDTH.
AUTO_INC, 0, 1 enables post-increment of write/read address and streaming reads.

Ports:
clk  input  1  system/SPI clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
SS_n  input  1  slave select, active-low
MOSI  input  1  serial data in, MSB first
MISO  output  1  serial data out, MSB first
busy  output  1  high whenever state != IDLE
frame_err  output  1  one-cycle pulse on a rejected frame

Behaviour:
- Reset (rst=1 at a rising edge) overrides all other activity, including mid-frame and mid-readout:
  - state=IDLE; MISO=0, busy=0, frame_err=0.
  - wr_addr=0, rd_addr=0, rd_addr_valid=0.
  - RAM contents are not reset.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE -> CHK_CMD on an edge with SS_n=0.
- CHK_CMD samples MOSI (select bit):
  - 0 -> WRITE.
  - 1 and rd_addr_valid=0 -> READ_ADD.
  - 1 and rd_addr_valid=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA shift FW bits, MSB first, one per edge. The frame is decoded on the edge after its last bit; cmd = frame[FW-1:FW-2]:
  - 00 in WRITE: wr_addr <= payload.
  - 01 in WRITE: mem[wr_addr] <= payload. If AUTO_INC, wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
  - 10 in READ_ADD: rd_addr <= payload; rd_addr_valid <= 1.
  - 11 in READ_DATA: RAM read issued. The first MISO bit (data MSB) is driven from 2 edges after the last frame bit, and each bit is held 1 cycle for DATA_WIDTH cycles. MISO returns to 0 after the LSB.
  - Read ends: AUTO_INC=0 clears rd_addr_valid. AUTO_INC=1 keeps it set and increments rd_addr (with wrap).
- Streaming read (AUTO_INC=1 only): if SS_n is still 0 after the LSB, the next word (incremented rd_addr) is output after a 1-cycle gap (MISO=0), repeating until SS_n=1.
- Frame error: cmd not legal for the current state, or address >= MEM_DEPTH, gives:
  - frame_err pulse on the decode edge;
  - no RAM write, no address/flag update, no MISO readout.
- After frame decode (or readout end) the FSM waits in its state with no further shifting until SS_n=1, then returns to IDLE.
- SS_n=1 at any edge in a non-IDLE state -> IDLE on that edge:
  - a partial frame is discarded;
  - an in-progress readout stops (MISO=0);
  - flags and addresses are unchanged.
- A single write to the same address as a pending read address is allowed; the read returns the latest written value.

Decomposition:
- Shared package spi_ram_pkg holds:
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - the FSM state enum;
  - frame-width helper function FW(DATA_WIDTH).
- One sub-module, spi_ram_mem: synchronous single-port RAM (DATA_WIDTH x MEM_DEPTH, registered read, 1-cycle latency, write-enable, no reset).
- The top holds the FSM, shift registers, address counters and MISO serializer.

Test Plan:
1. Defaults, AUTO_INC=0. Session select 0 + frame 0x0FF; session select 0 + frame 0x1B1 -> mem[0xFF]=0xB1, frame_err never asserted.
2. Read back. Select 1 + frame 0x2FF; select 1 + frame 0x3BC -> MISO=1,0,1,1,0,0,0,1 starting 2 cycles after the last frame bit; rd_addr_valid=0 afterwards, so the next select-1 session enters READ_ADD.
3. AUTO_INC=1:
   - 0x010 write-address frame, then 0x1AA and 0x155 frames in separate sessions -> mem[0x10]=0xAA, mem[0x11]=0x55.
   - 0x210, 0x3xx with SS_n held low -> MISO streams 0xAA, 1-cycle gap, 0x55.
4. Error:
   - select 0 then frame 0x2FE -> frame_err single-cycle pulse, wr_addr/RAM/rd_addr_valid unchanged;
   - MEM_DEPTH=200, write-address frame 0x0C8 -> frame_err pulse, wr_addr unchanged.
5. Abort: SS_n=1 after 5 bits of frame 0x1CC -> state IDLE same edge, busy=0, mem unchanged; the next full write-data frame still works.
6. Reset: assert rst during the 3rd MISO bit of a readout -> next edge MISO=0, busy=0, rd_addr_valid=0; RAM keeps 0xB1 at 0xFF, verified by a subsequent read.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM slave: command codes, FSM state encoding, frame width.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StChkCmd   = 3'd1;
  localparam state_t StWrite    = 3'd2;
  localparam state_t StReadAdd  = 3'd3;
  localparam state_t StReadData = 3'd4;

  // A frame is a 2-bit command followed by a DATA_WIDTH payload.
  function automatic int unsigned FW(input int unsigned data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with registered read (1-cycle latency); contents are not reset.
module spi_ram_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_slave_p.sv
// SPI slave fronting an on-chip RAM: frame shifter, command decode, address counters and
// MISO serializer. The SPI bit clock is the system clock.
module spi_ram_slave_p
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned AUTO_INC   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned FrameW  = FW(DATA_WIDTH);
  localparam int unsigned BitCntW = $clog2(FrameW + 1);
  localparam int unsigned OutCntW = $clog2(DATA_WIDTH + 1);

  state_t                state_q, state_d;
  logic [FrameW-1:0]     frame_q, frame_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_addr_valid_q, rd_addr_valid_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  out_active_q, out_active_d;
  logic [DATA_WIDTH-1:0] out_sr_q, out_sr_d;
  logic [OutCntW-1:0]    out_cnt_q, out_cnt_d;
  logic                  miso_q, miso_d;
  logic                  frame_err_q, frame_err_d;

  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_WIDTH-1:0] pay_addr, rd_addr_inc, wr_addr_inc;
  logic                  addr_ok, legal;
  logic                  mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign cmd         = frame_q[FrameW-1 -: 2];
  assign payload     = frame_q[DATA_WIDTH-1:0];
  assign pay_addr    = payload[ADDR_WIDTH-1:0];
  assign addr_ok     = 32'(pay_addr) < MEM_DEPTH;
  assign rd_addr_inc = addr_inc(rd_addr_q);
  assign wr_addr_inc = addr_inc(wr_addr_q);

  // Commands with cmd[0]=0 carry an address in the payload and must be range-checked.
  assign legal = ((state_q == StWrite    && !cmd[1]) ||
                  (state_q == StReadAdd  && cmd == CMD_RD_ADDR) ||
                  (state_q == StReadData && cmd == CMD_RD_DATA)) && (cmd[0] || addr_ok);

  always_comb begin
    state_d         = state_q;
    frame_d         = frame_q;
    bit_cnt_d       = bit_cnt_q;
    done_d          = done_q;
    wr_addr_d       = wr_addr_q;
    rd_addr_d       = rd_addr_q;
    rd_addr_valid_d = rd_addr_valid_q;
    rd_pend_d       = 1'b0;
    out_active_d    = out_active_q;
    out_sr_d        = out_sr_q;
    out_cnt_d       = out_cnt_q;
    miso_d          = miso_q;
    frame_err_d     = 1'b0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    mem_addr        = wr_addr_q;

    if (state_q != StIdle && SS_n) begin
      state_d      = StIdle;
      miso_d       = 1'b0;
      out_active_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!SS_n) begin
            state_d      = StChkCmd;
            bit_cnt_d    = '0;
            done_d       = 1'b0;
            out_active_d = 1'b0;
            miso_d       = 1'b0;
          end
        end
        StChkCmd: state_d = !MOSI ? StWrite : (rd_addr_valid_q ? StReadData : StReadAdd);
        StWrite, StReadAdd, StReadData: begin
          if (!done_q) begin
            if (bit_cnt_q != BitCntW'(FrameW)) begin
              frame_d   = {frame_q[FrameW-2:0], MOSI};
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end else begin
              done_d = 1'b1;
              if (!legal) begin
                frame_err_d = 1'b1;
              end else begin
                case (cmd)
                  CMD_WR_ADDR: wr_addr_d = pay_addr;
                  CMD_WR_DATA: begin
                    mem_we = 1'b1;
                    if (AUTO_INC != 0) wr_addr_d = wr_addr_inc;
                  end
                  CMD_RD_ADDR: begin
                    rd_addr_d       = pay_addr;
                    rd_addr_valid_d = 1'b1;
                  end
                  default: begin
                    mem_re    = 1'b1;
                    mem_addr  = rd_addr_q;
                    rd_pend_d = 1'b1;
                  end
                endcase
              end
            end
          end else if (rd_pend_q) begin
            miso_d       = mem_rdata[DATA_WIDTH-1];
            out_sr_d     = mem_rdata << 1;
            out_cnt_d    = OutCntW'(DATA_WIDTH - 1);
            out_active_d = 1'b1;
          end else if (out_active_q) begin
            if (out_cnt_q != '0) begin
              miso_d    = out_sr_q[DATA_WIDTH-1];
              out_sr_d  = out_sr_q << 1;
              out_cnt_d = out_cnt_q - OutCntW'(1);
            end else begin
              // LSB done: MISO idles for one cycle while the next word (if any) is fetched.
              miso_d       = 1'b0;
              out_active_d = 1'b0;
              if (AUTO_INC != 0) begin
                rd_addr_d = rd_addr_inc;
                mem_re    = 1'b1;
                mem_addr  = rd_addr_inc;
                rd_pend_d = 1'b1;
              end else begin
                rd_addr_valid_d = 1'b0;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      frame_q         <= '0;
      bit_cnt_q       <= '0;
      done_q          <= 1'b0;
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      rd_addr_valid_q <= 1'b0;
      rd_pend_q       <= 1'b0;
      out_active_q    <= 1'b0;
      out_sr_q        <= '0;
      out_cnt_q       <= '0;
      miso_q          <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_q         <= frame_d;
      bit_cnt_q       <= bit_cnt_d;
      done_q          <= done_d;
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      rd_addr_valid_q <= rd_addr_valid_d;
      rd_pend_q       <= rd_pend_d;
      out_active_q    <= out_active_d;
      out_sr_q        <= out_sr_d;
      out_cnt_q       <= out_cnt_d;
      miso_q          <= miso_d;
      frame_err_q     <= frame_err_d;
    end
  end

  spi_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(payload),
    .rdata_o(mem_rdata)
  );

  assign MISO      = miso_q;
  assign busy      = state_q != StIdle;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Directed bench: three instances (default, auto-increment, 200-word depth) on a shared clock.
module tb_spi_ram_slave_p;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ss_n;
  logic [2:0] mosi;
  wire  [2:0] miso;
  wire  [2:0] busy;
  wire  [2:0] ferr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_ram_slave_p #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut_base (
    .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .busy(busy[0]), .frame_err(ferr[0])
  );

  spi_ram_slave_p #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut_inc (
    .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .busy(busy[1]), .frame_err(ferr[1])
  );

  spi_ram_slave_p #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(0)) dut_d200 (
    .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi[2]),
    .MISO(miso[2]), .busy(busy[2]), .frame_err(ferr[2])
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_sess(input int d, input logic sel);
    ss_n[d] = 1'b0;
    mosi[d] = 1'b0;
    tick();
    mosi[d] = sel;
    tick();
  endtask

  task automatic shift_bits(input int d, input logic [9:0] f, input int n);
    for (int i = 9; i > 9 - n; i--) begin
      mosi[d] = f[i];
      tick();
    end
  endtask

  task automatic close_sess(input int d);
    ss_n[d] = 1'b1;
    mosi[d] = 1'b0;
    tick();
  endtask

  // Returns frame_err as seen just after the decode edge.
  task automatic send_frame(input int d, input logic sel, input logic [9:0] f, output logic err);
    open_sess(d, sel);
    shift_bits(d, f, 10);
    tick();
    err = ferr[d];
  endtask

  // Called right after the decode edge (or the inter-word gap edge); samples 8 MISO bits.
  task automatic read_word(input int d, output logic [7:0] w);
    tick();
    for (int b = 7; b >= 0; b--) begin
      w[b] = miso[d];
      tick();
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ss_n = 3'b111;
    mosi = 3'b000;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({miso[d], busy[d], ferr[d]} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: miso/busy/ferr=%b expected 000", d,
                 {miso[d], busy[d], ferr[d]});
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic e;
    open_sess(0, 1'b0);
    n_vec++;
    if (busy[0] !== 1'b1) begin
      n_err++; $display("FAIL busy_in_session: busy=%b expected 1", busy[0]);
    end
    shift_bits(0, 10'h0FF, 10);
    tick();
    n_vec++;
    if (ferr[0] !== 1'b0) begin
      n_err++; $display("FAIL wr_addr_ff: frame_err=%b expected 0", ferr[0]);
    end
    close_sess(0);
    n_vec++;
    if (busy[0] !== 1'b0) begin
      n_err++; $display("FAIL busy_after_close: busy=%b expected 0", busy[0]);
    end
    send_frame(0, 1'b0, 10'h1B1, e);
    n_vec++;
    if (e !== 1'b0) begin
      n_err++; $display("FAIL wr_data_b1: frame_err=%b expected 0", e);
    end
    close_sess(0);
  endtask

  task automatic test_read();
    logic       e;
    logic [7:0] w;
    send_frame(0, 1'b1, 10'h2FF, e);
    n_vec++;
    if (e !== 1'b0) begin
      n_err++; $display("FAIL rd_addr_ff: frame_err=%b expected 0", e);
    end
    close_sess(0);
    send_frame(0, 1'b1, 10'h3BC, e);
    n_vec++;
    if ({e, miso[0]} !== 2'b00) begin
      n_err++; $display("FAIL rd_data_decode: ferr,miso=%b expected 00", {e, miso[0]});
    end
    read_word(0, w);
    n_vec++;
    if (w !== 8'hB1) begin
      n_err++; $display("FAIL read_ff: got %h expected b1", w);
    end
    n_vec++;
    if (miso[0] !== 1'b0) begin
      n_err++; $display("FAIL miso_after_lsb: miso=%b expected 0", miso[0]);
    end
    close_sess(0);
    // Read address consumed, so select=1 now lands in READ_ADD and a read-data frame is rejected.
    send_frame(0, 1'b1, 10'h3BC, e);
    n_vec++;
    if (e !== 1'b1) begin
      n_err++; $display("FAIL rd_valid_cleared: frame_err=%b expected 1", e);
    end
    close_sess(0);
  endtask

  task automatic test_auto_inc();
    logic       e;
    logic [7:0] w;
    logic [9:0] frames [3];
    frames = '{10'h010, 10'h1AA, 10'h155};
    for (int i = 0; i < 3; i++) begin
      send_frame(1, 1'b0, frames[i], e);
      n_vec++;
      if (e !== 1'b0) begin
        n_err++; $display("FAIL inc_write_%0d: frame_err=%b expected 0", i, e);
      end
      close_sess(1);
    end
    send_frame(1, 1'b1, 10'h210, e);
    close_sess(1);
    send_frame(1, 1'b1, 10'h300, e);
    read_word(1, w);
    n_vec++;
    if (w !== 8'hAA) begin
      n_err++; $display("FAIL stream_word0: got %h expected aa", w);
    end
    n_vec++;
    if (miso[1] !== 1'b0) begin
      n_err++; $display("FAIL stream_gap: miso=%b expected 0", miso[1]);
    end
    read_word(1, w);
    n_vec++;
    if (w !== 8'h55) begin
      n_err++; $display("FAIL stream_word1: got %h expected 55", w);
    end
    close_sess(1);
  endtask

  task automatic test_frame_err();
    logic       e;
    logic [7:0] w;
    send_frame(0, 1'b0, 10'h2FE, e);
    n_vec++;
    if (e !== 1'b1) begin
      n_err++; $display("FAIL bad_cmd_in_write: frame_err=%b expected 1", e);
    end
    tick();
    n_vec++;
    if ({ferr[0], miso[0]} !== 2'b00) begin
      n_err++; $display("FAIL err_pulse_width: ferr,miso=%b expected 00", {ferr[0], miso[0]});
    end
    close_sess(0);
    // Depth-200 instance: out-of-range address rejected, wr_addr untouched.
    send_frame(2, 1'b0, 10'h005, e);
    close_sess(2);
    send_frame(2, 1'b0, 10'h1AB, e);
    close_sess(2);
    send_frame(2, 1'b0, 10'h0C8, e);
    n_vec++;
    if (e !== 1'b1) begin
      n_err++; $display("FAIL addr_200: frame_err=%b expected 1", e);
    end
    close_sess(2);
    send_frame(2, 1'b0, 10'h1CD, e);
    close_sess(2);
    send_frame(2, 1'b1, 10'h205, e);
    close_sess(2);
    send_frame(2, 1'b0, 10'h2FE, e);
    n_vec++;
    if (e !== 1'b1) begin
      n_err++; $display("FAIL bad_cmd_d200: frame_err=%b expected 1", e);
    end
    close_sess(2);
    send_frame(2, 1'b1, 10'h300, e);
    n_vec++;
    if (e !== 1'b0) begin
      n_err++; $display("FAIL rd_valid_kept: frame_err=%b expected 0", e);
    end
    read_word(2, w);
    n_vec++;
    if (w !== 8'hCD) begin
      n_err++; $display("FAIL read_after_err: got %h expected cd", w);
    end
    close_sess(2);
    send_frame(2, 1'b0, 10'h0C7, e);
    n_vec++;
    if (e !== 1'b0) begin
      n_err++; $display("FAIL addr_199: frame_err=%b expected 0", e);
    end
    close_sess(2);
  endtask

  task automatic test_abort();
    logic       e;
    logic [7:0] w;
    open_sess(0, 1'b0);
    shift_bits(0, 10'h1CC, 5);
    n_vec++;
    if (busy[0] !== 1'b1) begin
      n_err++; $display("FAIL busy_mid_frame: busy=%b expected 1", busy[0]);
    end
    ss_n[0] = 1'b1;
    tick();
    n_vec++;
    if ({busy[0], ferr[0]} !== 2'b00) begin
      n_err++; $display("FAIL abort_idle: busy,ferr=%b expected 00", {busy[0], ferr[0]});
    end
    send_frame(0, 1'b0, 10'h010, e);
    close_sess(0);
    send_frame(0, 1'b0, 10'h1CC, e);
    n_vec++;
    if (e !== 1'b0) begin
      n_err++; $display("FAIL write_after_abort: frame_err=%b expected 0", e);
    end
    close_sess(0);
    send_frame(0, 1'b1, 10'h210, e);
    close_sess(0);
    send_frame(0, 1'b1, 10'h300, e);
    read_word(0, w);
    n_vec++;
    if (w !== 8'hCC) begin
      n_err++; $display("FAIL read_after_abort: got %h expected cc", w);
    end
    close_sess(0);
  endtask

  task automatic test_reset_mid_read();
    logic       e;
    logic [7:0] w;
    send_frame(0, 1'b1, 10'h2FF, e);
    close_sess(0);
    send_frame(0, 1'b1, 10'h300, e);
    tick();
    tick();
    tick();
    n_vec++;
    if (miso[0] !== 1'b1) begin
      n_err++; $display("FAIL third_bit: miso=%b expected 1", miso[0]);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({miso[0], busy[0]} !== 2'b00) begin
      n_err++; $display("FAIL reset_mid_read: miso,busy=%b expected 00", {miso[0], busy[0]});
    end
    rst     = 1'b0;
    ss_n[0] = 1'b1;
    mosi[0] = 1'b0;
    tick();
    send_frame(0, 1'b1, 10'h300, e);
    n_vec++;
    if (e !== 1'b1) begin
      n_err++; $display("FAIL rd_valid_reset: frame_err=%b expected 1", e);
    end
    close_sess(0);
    send_frame(0, 1'b1, 10'h2FF, e);
    close_sess(0);
    send_frame(0, 1'b1, 10'h300, e);
    read_word(0, w);
    n_vec++;
    if (w !== 8'hB1) begin
      n_err++; $display("FAIL ram_kept_over_reset: got %h expected b1", w);
    end
    close_sess(0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_auto_inc();
    test_frame_err();
    test_abort();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
